// File: rtl/mem32k_ctrl.sv
// mem32k_ctrl -- synchronous initiator for the 32K x 8 asynchronous SRAM.
// Turns single-beat host read/write requests into CS/OE/WE strobe sequences
// with programmable setup, pulse and hold wait states.
//
// Ports:
//   CLK    system clock (rising edge)
//   RST_N  asynchronous active-low reset
//   REQ    host request, sampled only in IDLE
//   RW     1 = write, 0 = read; sampled with REQ
//   ADDR   host address; sampled with REQ
//   WDATA  write data; sampled with REQ
//   RDATA  read data; valid from DONE until the next read completes
//   BUSY   high in every non-IDLE state
//   DONE   one-cycle completion pulse
//   A      SRAM address
//   IO     SRAM data bus; driven only during write transactions
//   CS/OE/WE  SRAM strobes, active-low
module mem32k_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic        RW,
  input  logic [0:14] ADDR,
  input  logic [0:7]  WDATA,
  output logic [0:7]  RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [0:14] A,
  inout  wire  [0:7]  IO,
  output logic        CS,
  output logic        OE,
  output logic        WE
);

  if (SETUP_CYC < 1 || SETUP_CYC > 255 ||
      PULSE_CYC < 1 || PULSE_CYC > 255 ||
      HOLD_CYC  < 1 || HOLD_CYC  > 255) begin : g_bad_param
    $error("mem32k_ctrl: SETUP_CYC/PULSE_CYC/HOLD_CYC must be in 1..255");
  end

  // The counter is loaded with N-1 so a timed state lasts exactly N cycles.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [0:14] addr_d;
  logic [0:7]  wdata_q, wdata_d;
  logic [0:7]  rdata_d;
  logic        io_en_q, io_en_d;
  logic        cs_d, oe_d, we_d, busy_d, done_d;

  assign IO = io_en_q ? wdata_q : 'z;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = A;
    wdata_d = wdata_q;
    rdata_d = RDATA;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          rw_d    = RW;
          addr_d  = ADDR;
          wdata_d = WDATA;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ACCESS;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          // Sample the SRAM while OE is still low on the edge that raises it.
          if (!rw_q) rdata_d = IO;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so every
  // output pin comes straight from a flop.
  always_comb begin
    cs_d    = !(state_d inside {ST_SETUP, ST_ACCESS, ST_HOLD});
    we_d    = !(state_d == ST_ACCESS && rw_d);
    oe_d    = !(state_d == ST_ACCESS && !rw_d);
    io_en_d = !cs_d && rw_d;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      A       <= '0;
      wdata_q <= '0;
      RDATA   <= '0;
      io_en_q <= 1'b0;
      CS      <= 1'b1;
      OE      <= 1'b1;
      WE      <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      A       <= addr_d;
      wdata_q <= wdata_d;
      RDATA   <= rdata_d;
      io_en_q <= io_en_d;
      CS      <= cs_d;
      OE      <= oe_d;
      WE      <= we_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
    end
  end

endmodule

// File: tb/tb_mem32k_ctrl.sv
// tb_mem32k_ctrl -- self-checking bench for mem32k_ctrl.
// Two instances (default timing and 3/4/2 timing), each on its own
// behavioural 32K x 8 SRAM. A reference memory in the bench predicts read
// data; a per-cycle monitor checks strobe legality and IO bus ownership.
module tb_mem32k_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req [2];
  logic        rw_i = 1'b0;
  logic [0:14] addr_i = '0;
  logic [0:7]  wdata_i = '0;
  logic [0:7]  rdata [2];
  logic        busy [2];
  logic        done [2];
  logic [0:14] a [2];
  logic        cs [2];
  logic        oe [2];
  logic        we [2];
  wire  [0:7]  io0;
  wire  [0:7]  io1;

  logic [7:0]  mem0 [0:32767];
  logic [7:0]  mem1 [0:32767];
  logic [7:0]  ref_mem [int];
  logic [7:0]  last_rd [2];
  logic        cur_read [2];
  logic [7:0]  cur_wdata [2];
  logic [0:7]  probe [2];
  int          done_cnt [2];
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  mem32k_ctrl u_dut0 (
    .CLK(clk), .RST_N(rst_n), .REQ(req[0]), .RW(rw_i), .ADDR(addr_i),
    .WDATA(wdata_i), .RDATA(rdata[0]), .BUSY(busy[0]), .DONE(done[0]),
    .A(a[0]), .IO(io0), .CS(cs[0]), .OE(oe[0]), .WE(we[0])
  );

  mem32k_ctrl #(.SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .REQ(req[1]), .RW(rw_i), .ADDR(addr_i),
    .WDATA(wdata_i), .RDATA(rdata[1]), .BUSY(busy[1]), .DONE(done[1]),
    .A(a[1]), .IO(io1), .CS(cs[1]), .OE(oe[1]), .WE(we[1])
  );

  // Behavioural SRAMs: drive on CS&OE low, capture on the rising WE edge.
  assign io0 = (!cs[0] && !oe[0]) ? mem0[a[0]] : 'z;
  assign io1 = (!cs[1] && !oe[1]) ? mem1[a[1]] : 'z;
  always @(posedge we[0]) if (!cs[0]) mem0[a[0]] = io0;
  always @(posedge we[1]) if (!cs[1]) mem1[a[1]] = io1;

  // Probe driver: whenever the controller must have released IO and the SRAM
  // is not driving, the bench drives a random pattern; any contention by the
  // controller corrupts it.
  assign io0 = ((!busy[0] || done[0] || cur_read[0]) && oe[0]) ? probe[0] : 'z;
  assign io1 = ((!busy[1] || done[1] || cur_read[1]) && oe[1]) ? probe[1] : 'z;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] sram_rd(input int s, input logic [14:0] ad);
    return (s == 0) ? mem0[ad] : mem1[ad];
  endfunction

  task automatic mon(input int s, input logic [0:7] io_v);
    check("we_oe_exclusive", {31'd0, (!we[s] && !oe[s])}, 32'd0);
    check("strobe_without_cs", {31'd0, ((!we[s] || !oe[s]) && cs[s])}, 32'd0);
    if ((!busy[s] || done[s] || cur_read[s]) && oe[s])
      check("io_released", io_v, probe[s]);
    else if (busy[s] && !done[s] && !cur_read[s])
      check("io_wdata", io_v, cur_wdata[s]);
    if (done[s]) done_cnt[s]++;
    probe[s] = 8'($urandom);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, io0);
      mon(1, io1);
    end
  end

  task automatic txn(input int s, input bit wr, input logic [14:0] ad,
                     input logic [7:0] d, input bit spam);
    int k, lat, pc, cs_lo, we_lo, oe_lo, dc0, key;
    bit got;
    logic [7:0] exp_rd;
    lat = (s == 0) ? 4 : 9;
    pc  = (s == 0) ? 2 : 4;
    key = s * 32768 + int'(ad);
    @(negedge clk);
    rw_i = wr; addr_i = ad; wdata_i = d;
    cur_read[s] = !wr; cur_wdata[s] = d;
    dc0 = done_cnt[s];
    req[s] = 1'b1;
    @(posedge clk); #1;
    check("accept_busy", {31'd0, busy[s]}, 32'd1);
    check("accept_cs", {31'd0, cs[s]}, 32'd0);
    check("addr_out", {17'd0, a[s]}, {17'd0, ad});
    cs_lo = int'(!cs[s]); we_lo = int'(!we[s]); oe_lo = int'(!oe[s]);
    k = 0; got = 1'b0;
    while (!got && k < 64) begin
      @(negedge clk);
      req[s] = spam;
      if (spam) begin
        addr_i = 15'($urandom); wdata_i = 8'($urandom); rw_i = 1'($urandom);
      end
      @(posedge clk); #1;
      k++;
      if (done[s]) got = 1'b1;
      else begin
        cs_lo += int'(!cs[s]); we_lo += int'(!we[s]); oe_lo += int'(!oe[s]);
        check("addr_hold", {17'd0, a[s]}, {17'd0, ad});
      end
    end
    check("done_seen", {31'd0, got}, 32'd1);
    check("done_latency", k, lat);
    check("cs_low_cycles", cs_lo, lat);
    check("we_low_cycles", we_lo, wr ? pc : 0);
    check("oe_low_cycles", oe_lo, wr ? 0 : pc);
    check("cs_high_in_done", {31'd0, cs[s]}, 32'd1);
    if (wr) begin
      ref_mem[key] = d;
      check("rdata_kept", {24'd0, rdata[s]}, {24'd0, last_rd[s]});
    end else begin
      exp_rd = ref_mem.exists(key) ? ref_mem[key] : 8'h00;
      check("rdata", {24'd0, rdata[s]}, {24'd0, exp_rd});
      last_rd[s] = exp_rd;
    end
    @(negedge clk);
    if (wr) check("sram_word", {24'd0, sram_rd(s, ad)}, {24'd0, d});
    @(posedge clk); #1;
    check("idle_busy", {31'd0, busy[s]}, 32'd0);
    check("done_one_cycle", {31'd0, done[s]}, 32'd0);
    @(negedge clk);
    req[s] = 1'b0;
    check("done_count", done_cnt[s] - dc0, 1);
    if (spam) begin
      @(posedge clk); #1;
      check("done_req_ignored", {31'd0, busy[s]}, 32'd0);
    end
  endtask

  task automatic reset_check(input int s);
    check("rst_cs", {31'd0, cs[s]}, 32'd1);
    check("rst_oe", {31'd0, oe[s]}, 32'd1);
    check("rst_we", {31'd0, we[s]}, 32'd1);
    check("rst_busy", {31'd0, busy[s]}, 32'd0);
    check("rst_done", {31'd0, done[s]}, 32'd0);
    check("rst_rdata", {24'd0, rdata[s]}, 32'd0);
    check("rst_addr", {17'd0, a[s]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, dc0;
    logic [14:0] ad;
    for (int i = 0; i < 32768; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; last_rd[i] = 8'h00; cur_read[i] = 1'b0;
      cur_wdata[i] = 8'h00; probe[i] = 8'h3C; done_cnt[i] = 0;
    end
    #1 rst_n = 1'b0;
    #22;
    reset_check(0);
    reset_check(1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Basic write/read-back and address extremes.
    txn(0, 1'b1, 15'h0000, 8'h01, 1'b0);
    txn(0, 1'b0, 15'h0000, 8'h00, 1'b0);
    txn(0, 1'b1, 15'h7FFF, 8'hA5, 1'b0);
    txn(0, 1'b1, 15'h0000, 8'h5A, 1'b0);
    txn(0, 1'b0, 15'h7FFF, 8'h00, 1'b0);
    txn(0, 1'b0, 15'h0000, 8'h00, 1'b0);
    check("no_alias_7fff", {24'd0, mem0[15'h7FFF]}, 32'hA5);

    // Requests hammered while busy are dropped.
    txn(0, 1'b0, 15'h7FFF, 8'h00, 1'b1);
    txn(0, 1'b1, 15'h0003, 8'hC3, 1'b1);

    // Asynchronous reset during the ACCESS phase of a write.
    @(negedge clk);
    rw_i = 1'b1; addr_i = 15'h1234; wdata_i = 8'h77;
    cur_read[0] = 1'b0; cur_wdata[0] = 8'h77; req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    k = 0;
    while (we[0] && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("we_reached", {31'd0, we[0]}, 32'd0);
    dc0 = done_cnt[0];
    #2 rst_n = 1'b0;
    #1;
    reset_check(0);
    check("rst_io_released", {24'd0, io0}, {24'd0, probe[0]});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1 check("no_done_after_reset", done_cnt[0] - dc0, 0);
    txn(0, 1'b1, 15'h1234, 8'h96, 1'b0);
    txn(0, 1'b0, 15'h1234, 8'h00, 1'b0);
    txn(0, 1'b0, 15'h0003, 8'h00, 1'b0);

    // Stretched timing instance.
    txn(1, 1'b1, 15'h7FFF, 8'hE7, 1'b0);
    txn(1, 1'b1, 15'h0000, 8'h18, 1'b0);
    txn(1, 1'b0, 15'h7FFF, 8'h00, 1'b0);
    txn(1, 1'b0, 15'h0000, 8'h00, 1'b1);

    // Randomized traffic over a small address pool at both ends of the range.
    for (int i = 0; i < 60; i++) begin
      ad = ($urandom_range(0, 1) == 0) ? 15'($urandom_range(0, 7))
                                       : 15'(15'h7FF8 + 15'($urandom_range(0, 7)));
      txn((i % 3 == 2) ? 1 : 0, 1'($urandom_range(0, 1)), ad, 8'($urandom),
          ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
